// File: rtl/bus_arb_pkg.sv
// Shared constants, FSM state type and index helpers for the CPU bus grant arbiter.
package bus_arb_pkg;

  localparam int N_SRC = 32;
  localparam int IDX_W = 5;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic logic [N_SRC-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [N_SRC-1:0] one;
    one      = '0;
    one[idx] = 1'b1;
    return one;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first set bit of mask scanning upward from start, wrapping 31->0.
// Purely combinational, zero latency; no flow control.
module rr_priority_pick
  import bus_arb_pkg::*;
(
  input  logic [N_SRC-1:0] mask,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [N_SRC-1:0] rot;
  logic [IDX_W-1:0] off;

  always_comb begin
    // Rotate so that bit 'start' lands at position 0, then find the lowest set bit.
    rot = N_SRC'({mask, mask} >> start);
    off = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    idx   = start + off;
    found = |mask;
  end

endmodule

// File: rtl/bus_grant_arbiter.sv
// Round-robin owner select for the shared CPU bus with bounded hold time; all outputs registered,
// one cycle from req to grant. Sources hold req level-high to keep the bus; there is no other backpressure.
module bus_grant_arbiter
  import bus_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [N_SRC-1:0] req,
  output logic [N_SRC-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             bus_valid,
  output logic             grant_new
);

  localparam int HOLD_W = (MAX_HOLD == 0) ? 3 : $clog2(MAX_HOLD + 1);
  // With preemption disabled the counter just saturates at all-ones.
  localparam logic [HOLD_W-1:0] HOLD_SAT = (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_W'(MAX_HOLD);

  localparam logic [0:0] ST_IDLE  = IDLE;
  localparam logic [0:0] ST_GRANT = GRANT;

  logic [0:0]       state;
  logic [IDX_W-1:0] ptr;
  logic [HOLD_W-1:0] hold_cnt;

  logic [N_SRC-1:0] cand;
  logic             others;
  logic             own;
  logic             at_limit;
  logic             take;
  logic             release_bus;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;

  rr_priority_pick u_pick (
    .mask  (cand),
    .start (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    cand        = req & ~grant;
    others      = |cand;
    own         = |(req & grant);
    at_limit    = (MAX_HOLD != 0) && (hold_cnt == HOLD_SAT);
    take        = 1'b0;
    release_bus = 1'b0;
    if (state == ST_IDLE) begin
      take = pick_found;
    end else if (!own && others) begin
      take = 1'b1;
    end else if (!own) begin
      release_bus = 1'b1;
    end else if (at_limit && others) begin
      take = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      grant     <= '0;
      grant_idx <= '0;
      bus_valid <= 1'b0;
      grant_new <= 1'b0;
    end else if (take) begin
      state     <= ST_GRANT;
      ptr       <= pick_idx + 1'b1;
      hold_cnt  <= HOLD_W'(1);
      grant     <= idx_to_onehot(pick_idx);
      grant_idx <= pick_idx;
      bus_valid <= 1'b1;
      grant_new <= 1'b1;
    end else if (release_bus) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      grant     <= '0;
      grant_idx <= '0;
      bus_valid <= 1'b0;
      grant_new <= 1'b0;
    end else begin
      grant_new <= 1'b0;
      if (state == ST_GRANT && hold_cnt != HOLD_SAT) hold_cnt <= hold_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_grant_arbiter.sv
// Scoreboard bench: stimulus pushes model predictions, a monitor pops and compares each cycle.
module tb_bus_grant_arbiter;

  localparam int MH = 4;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] req;
  logic [31:0] grant;
  logic [4:0]  grant_idx;
  logic        bus_valid;
  logic        grant_new;

  bus_grant_arbiter #(.MAX_HOLD(MH)) dut (
    .clock     (clock),
    .clear     (clear),
    .req       (req),
    .grant     (grant),
    .grant_idx (grant_idx),
    .bus_valid (bus_valid),
    .grant_new (grant_new)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] grant;
    int          idx;
    bit          valid;
    bit          gnew;
    int          phase;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: owner index (-1 = bus idle), next scan start, cycles held.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  bit m_new   = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int phase    = 0;

  function automatic int rr_pick(input logic [31:0] m, input int p);
    for (int k = 0; k < 32; k++) begin
      int i;
      i = (p + k) % 32;
      if (m[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_take(input int p);
    m_owner = p;
    m_ptr   = (p + 1) % 32;
    m_hold  = 1;
    m_new   = 1'b1;
  endtask

  task automatic model_step(input logic [31:0] r, input bit c);
    logic [31:0] rest;
    bit          own;
    if (c) begin
      m_owner = -1; m_ptr = 0; m_hold = 0; m_new = 1'b0;
    end else if (m_owner < 0) begin
      m_new = 1'b0;
      if (r != 0) model_take(rr_pick(r, m_ptr));
    end else begin
      rest = r;
      rest[m_owner] = 1'b0;
      own = r[m_owner];
      if (rest != 0 && (!own || (MH != 0 && m_hold == MH))) begin
        model_take(rr_pick(rest, m_ptr));
      end else if (!own) begin
        m_owner = -1; m_hold = 0; m_new = 1'b0;
      end else begin
        m_new = 1'b0;
        if (MH == 0 || m_hold < MH) m_hold = m_hold + 1;
      end
    end
  endtask

  task automatic drive(input logic [31:0] r, input bit c);
    exp_t e;
    @(negedge clock);
    req   = r;
    clear = c;
    model_step(r, c);
    e.grant = (m_owner < 0) ? 32'h0 : (32'h1 << m_owner);
    e.idx   = (m_owner < 0) ? 0 : m_owner;
    e.valid = (m_owner >= 0);
    e.gnew  = m_new;
    e.phase = phase;
    exp_q.push_back(e);
  endtask

  task automatic chk(input bit ok, input string name, input int ph,
                     input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s (phase %0d): got %h, expected %h", name, ph, act, want);
  endtask

  // Monitor: one registered output set per cycle, sampled just after the edge.
  initial begin
    exp_t        e;
    logic [63:0] act, want;
    int          enc;
    bit          inv_ok;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e    = exp_q.pop_front();
        act  = {25'b0, grant, grant_idx, bus_valid, grant_new};
        want = {25'b0, e.grant, 5'(e.idx), e.valid, e.gnew};
        chk(act == want, "outputs", e.phase, act, want);
        inv_ok = $onehot0(grant) && (bus_valid == |grant) &&
                 (!bus_valid || grant == (32'h1 << grant_idx)) && (!grant_new || bus_valid);
        chk(inv_ok, "invariant", e.phase, {27'b0, grant_idx, grant}, {27'b0, grant_idx, e.grant});
        if (bus_valid) begin
          enc = 0;
          for (int i = 0; i < 32; i++) if (grant[i]) enc = i;
          chk(enc == int'(grant_idx), "encoder", e.phase, 64'(grant_idx), 64'(enc));
        end
      end
    end
  end

  initial begin
    logic [31:0] r;
    clear = 1'b1;
    req   = '0;

    phase = 1;  // reset with everyone requesting, then first grant goes to 0
    drive(32'hFFFF_FFFF, 1'b1);
    drive(32'hFFFF_FFFF, 1'b1);
    repeat (6) drive(32'hFFFF_FFFF, 1'b0);

    phase = 2;  // lone requester is never preempted, drop releases the bus
    drive(32'h0, 1'b1);
    drive(32'h0, 1'b0);
    repeat (11) drive(32'h0000_0100, 1'b0);
    repeat (2) drive(32'h0, 1'b0);

    phase = 3;  // two requesters at the ends, pointer wraps after 31
    drive(32'h0, 1'b1);
    repeat (20) drive(32'h8000_0001, 1'b0);

    phase = 4;  // same-edge handoff from 5 to 9
    drive(32'h0, 1'b1);
    repeat (2) drive(32'h0000_0020, 1'b0);
    repeat (3) drive(32'h0000_0200, 1'b0);

    phase = 5;  // clear mid-grant, then re-grant to 12
    drive(32'h0, 1'b1);
    repeat (3) drive(32'h0000_1000, 1'b0);
    drive(32'h0000_1000, 1'b1);
    repeat (3) drive(32'h0000_1000, 1'b0);

    phase = 6;
    r = '0;
    for (int n = 0; n < 5000; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0: r = '0;
          1: r = 32'h1 << $urandom_range(0, 31);
          2: r = $urandom & $urandom & $urandom;
          default: r = $urandom;
        endcase
      end
      drive(r, $urandom_range(0, 199) == 0);
    end

    repeat (3) @(posedge clock);
    #2;
    chk(exp_q.size() == 0, "drain", phase, 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
